// File: rtl/oled_spi_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : oled_spi_ctrl
//  Function : PMOD OLED power sequencer and SPI mode-0 byte engine with a
//             9-bit (D/C + byte) write FIFO. Each FIFO entry is sent MSB
//             first inside its own chip-select window.
//  Revision : 1.0  initial release
// ============================================================================
module oled_spi_ctrl #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int T_VDD      = 20000,
  parameter int T_RES      = 400
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       power_en,
  input  logic       vcc_on,
  input  logic       wr_en,
  input  logic [8:0] wr_data,
  input  logic       clr_ovf,
  output logic       full,
  output logic       ready,
  output logic       busy,
  output logic       overflow,
  output logic       OLED_CS,
  output logic       OLED_MOSI,
  output logic       OLED_SCK,
  output logic       OLED_DC,
  output logic       OLED_RES,
  output logic       OLED_VCC_EN,
  output logic       OLED_PMOD_EN,
  output logic       OLED_NC
);

  // One shared down-time counter covers the longest of the three delays.
  localparam int c_TMAX   = (T_VDD > T_RES) ? ((T_VDD > CLK_DIV) ? T_VDD : CLK_DIV)
                                            : ((T_RES > CLK_DIV) ? T_RES : CLK_DIV);
  localparam int c_CNT_W  = $clog2(c_TMAX + 1);
  localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
  localparam int c_FCNT_W = c_PTR_W + 1;

  typedef enum logic [3:0] {
    S_OFF      = 4'd0,
    S_VDD_WAIT = 4'd1,
    S_RES_LOW  = 4'd2,
    S_RES_WAIT = 4'd3,
    S_IDLE     = 4'd4,
    S_SETUP    = 4'd5,
    S_SHIFT    = 4'd6,
    S_HOLD     = 4'd7,
    S_GAP      = 4'd8
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [2:0]           r_bit;
  logic                 r_phase;
  logic [6:0]           r_sh;
  logic                 r_cs;
  logic                 r_sck;
  logic                 r_mosi;
  logic                 r_dc;
  logic                 r_res;
  logic                 r_pmod_en;
  logic                 r_ready;
  logic                 r_ovf;

  logic [8:0]           r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_FCNT_W-1:0]  r_count;

  logic                 w_in_byte;
  logic                 w_div_done;
  logic                 w_enter_off;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_push_ok;
  logic                 w_drop;
  logic [c_PTR_W-1:0]   w_wr_idx;
  logic [8:0]           w_head;

  assign w_in_byte  = (r_state == S_SETUP) || (r_state == S_SHIFT) ||
                      (r_state == S_HOLD)  || (r_state == S_GAP);
  assign w_div_done = (r_cnt == c_CNT_W'(CLK_DIV - 1));

  // Power-down is immediate outside a byte; inside a byte it waits for GAP end.
  assign w_enter_off = !power_en &&
                       ((r_state == S_VDD_WAIT) || (r_state == S_RES_LOW) ||
                        (r_state == S_RES_WAIT) || (r_state == S_IDLE)    ||
                        ((r_state == S_GAP) && w_div_done));

  assign w_pop     = (r_state == S_IDLE) && power_en && (r_count != '0);
  assign w_full    = (r_count == c_FCNT_W'(FIFO_DEPTH));
  // A flush frees the whole FIFO, so a push in that cycle always fits.
  assign w_push_ok = wr_en && (w_enter_off || !w_full || w_pop);
  assign w_drop    = wr_en && !w_push_ok;
  assign w_wr_idx  = w_enter_off ? '0 : r_wr_ptr;
  assign w_head    = r_mem[r_rd_ptr];

  assign full         = w_full;
  assign ready        = r_ready;
  assign busy         = (r_count != '0) || w_in_byte;
  assign overflow     = r_ovf;
  assign OLED_CS      = r_cs;
  assign OLED_MOSI    = r_mosi;
  assign OLED_SCK     = r_sck;
  assign OLED_DC      = r_dc;
  assign OLED_RES     = r_res;
  assign OLED_VCC_EN  = r_ready & vcc_on;
  assign OLED_PMOD_EN = r_pmod_en;
  assign OLED_NC      = 1'b0;

  // FIFO storage: no reset needed, validity is tracked by the pointers.
  always_ff @(posedge CLK) begin
    if (w_push_ok) begin
      r_mem[w_wr_idx] <= wr_data;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_enter_off) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= w_push_ok ? c_PTR_W'(1) : '0;
        r_count  <= w_push_ok ? c_FCNT_W'(1) : '0;
      end else begin
        if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
        if (w_pop)     r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
        case ({w_push_ok, w_pop})
          2'b10:   r_count <= r_count + c_FCNT_W'(1);
          2'b01:   r_count <= r_count - c_FCNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
      // A drop in the same cycle as a clear leaves the flag set.
      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

  // Sequencer and SPI engine; every pin is a register updated with the state.
  always_ff @(posedge CLK) begin
    if (reset || w_enter_off) begin
      r_state   <= S_OFF;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_phase   <= 1'b0;
      r_sh      <= '0;
      r_cs      <= 1'b1;
      r_sck     <= 1'b0;
      r_mosi    <= 1'b0;
      r_dc      <= 1'b0;
      r_res     <= 1'b1;
      r_pmod_en <= 1'b0;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        S_OFF: begin
          if (power_en) begin
            r_state   <= S_VDD_WAIT;
            r_pmod_en <= 1'b1;
            r_cnt     <= '0;
          end
        end
        S_VDD_WAIT: begin
          if (r_cnt == c_CNT_W'(T_VDD - 1)) begin
            r_state <= S_RES_LOW;
            r_res   <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        S_RES_LOW: begin
          if (r_cnt == c_CNT_W'(T_RES - 1)) begin
            r_state <= S_RES_WAIT;
            r_res   <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        S_RES_WAIT: begin
          if (r_cnt == c_CNT_W'(T_RES - 1)) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        S_IDLE: begin
          if (w_pop) begin
            r_state <= S_SETUP;
            r_cs    <= 1'b0;
            r_dc    <= w_head[8];
            r_mosi  <= w_head[7];
            r_sh    <= w_head[6:0];
            r_bit   <= '0;
            r_phase <= 1'b0;
            r_cnt   <= '0;
          end
        end
        S_SETUP: begin
          if (w_div_done) begin
            r_state <= S_SHIFT;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        S_SHIFT: begin
          if (w_div_done) begin
            r_cnt <= '0;
            if (!r_phase) begin
              r_phase <= 1'b1;
              r_sck   <= 1'b1;
            end else begin
              r_phase <= 1'b0;
              r_sck   <= 1'b0;
              if (r_bit == 3'd7) begin
                r_state <= S_HOLD;
              end else begin
                r_bit  <= r_bit + 3'd1;
                r_mosi <= r_sh[6];
                r_sh   <= {r_sh[5:0], 1'b0};
              end
            end
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (w_div_done) begin
            r_state <= S_GAP;
            r_cs    <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        S_GAP: begin
          if (w_div_done) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_OFF;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_oled_spi_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_oled_spi_ctrl
//  Function : directed self-checking bench for oled_spi_ctrl
//  Revision : 1.0  initial release
// ============================================================================
module tb_oled_spi_ctrl;
    localparam int CLK_DIV    = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int T_VDD      = 4;
    localparam int T_RES      = 3;

    logic       CLK;
    logic       reset, power_en, vcc_on, wr_en, clr_ovf;
    logic [8:0] wr_data;
    logic       full, ready, busy, overflow;
    logic       OLED_CS, OLED_MOSI, OLED_SCK, OLED_DC, OLED_RES;
    logic       OLED_VCC_EN, OLED_PMOD_EN, OLED_NC;

    oled_spi_ctrl #(
        .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .T_VDD(T_VDD), .T_RES(T_RES)
    ) dut (
        .CLK(CLK), .reset(reset), .power_en(power_en), .vcc_on(vcc_on),
        .wr_en(wr_en), .wr_data(wr_data), .clr_ovf(clr_ovf),
        .full(full), .ready(ready), .busy(busy), .overflow(overflow),
        .OLED_CS(OLED_CS), .OLED_MOSI(OLED_MOSI), .OLED_SCK(OLED_SCK),
        .OLED_DC(OLED_DC), .OLED_RES(OLED_RES), .OLED_VCC_EN(OLED_VCC_EN),
        .OLED_PMOD_EN(OLED_PMOD_EN), .OLED_NC(OLED_NC)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Edge counter: at a negedge, cyc equals the number of rising edges so far.
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [8:0] data;
        int         nb;
        int         len;
        int         start;
        int         stop;
        logic       pmod;
    } rx_t;

    rx_t        rx_q[$];
    rx_t        rx_tmp;
    logic       rx_active = 1'b0;
    logic [7:0] rx_bits   = '0;
    logic       rx_dc     = 1'b0;
    int         rx_nb     = 0;
    int         rx_len    = 0;
    int         rx_start  = 0;
    logic       prev_sck  = 1'b0;
    logic       prev_busy = 1'b0;
    int         busy_fall = 0;

    // SPI receiver model: one record per CS-low window, bits taken on SCK rise.
    always @(negedge CLK) begin
        if (OLED_CS == 1'b0) begin
            if (!rx_active) begin
                rx_active = 1'b1;
                rx_start  = cyc;
                rx_nb     = 0;
                rx_len    = 0;
                rx_bits   = '0;
                rx_dc     = OLED_DC;
            end
            rx_len = rx_len + 1;
            if (OLED_SCK && !prev_sck) begin
                rx_bits = {rx_bits[6:0], OLED_MOSI};
                rx_nb   = rx_nb + 1;
            end
        end else if (rx_active) begin
            rx_active    = 1'b0;
            rx_tmp.data  = {rx_dc, rx_bits};
            rx_tmp.nb    = rx_nb;
            rx_tmp.len   = rx_len;
            rx_tmp.start = rx_start;
            rx_tmp.stop  = cyc;
            rx_tmp.pmod  = OLED_PMOD_EN;
            rx_q.push_back(rx_tmp);
        end
        if (prev_busy && !busy) busy_fall = cyc;
        prev_busy = busy;
        prev_sck  = OLED_SCK;
    end

    task automatic chk(input string tag, input logic ok, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (ok !== 1'b1) begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge CLK);
            k++;
        end
        chk("rx_wait", rx_q.size() >= n, rx_q.size(), n);
    endtask

    task automatic wait_sck(input int budget);
        int k = 0;
        while (!OLED_SCK && k < budget) begin
            @(negedge CLK);
            k++;
        end
        chk("sck_wait", OLED_SCK === 1'b1, OLED_SCK, 1);
    endtask

    task automatic push(input logic [8:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge CLK);
        wr_en   = 1'b0;
    endtask

    logic [8:0] qd [5];
    int         first_res, res_cnt, first_ready, push_cyc;
    logic       pmod1;

    initial begin
        reset = 1'b1; power_en = 1'b0; vcc_on = 1'b0;
        wr_en = 1'b0; wr_data = '0; clr_ovf = 1'b0;
        qd[0] = 9'h111; qd[1] = 9'h022; qd[2] = 9'h133; qd[3] = 9'h044; qd[4] = 9'h155;
        idle(3);

        // Reset state
        chk("rst_cs",    OLED_CS === 1'b1,      OLED_CS, 1);
        chk("rst_res",   OLED_RES === 1'b1,     OLED_RES, 1);
        chk("rst_sck",   OLED_SCK === 1'b0,     OLED_SCK, 0);
        chk("rst_mosi",  OLED_MOSI === 1'b0,    OLED_MOSI, 0);
        chk("rst_dc",    OLED_DC === 1'b0,      OLED_DC, 0);
        chk("rst_vcc",   OLED_VCC_EN === 1'b0,  OLED_VCC_EN, 0);
        chk("rst_pmod",  OLED_PMOD_EN === 1'b0, OLED_PMOD_EN, 0);
        chk("rst_nc",    OLED_NC === 1'b0,      OLED_NC, 0);
        chk("rst_full",  full === 1'b0,         full, 0);
        chk("rst_ready", ready === 1'b0,        ready, 0);
        chk("rst_busy",  busy === 1'b0,         busy, 0);
        chk("rst_ovf",   overflow === 1'b0,     overflow, 0);
        reset = 1'b0;
        idle(1);

        // Fill the FIFO while powered off, then overrun it
        for (int i = 0; i < 5; i++) begin
            push(qd[i]);
            if (i == 2) chk("full_at3", full === 1'b0, full, 0);
            if (i == 3) begin
                chk("full_at4", full === 1'b1, full, 1);
                chk("ovf_at4", overflow === 1'b0, overflow, 0);
            end
        end
        chk("full_at5", full === 1'b1, full, 1);
        chk("ovf_at5", overflow === 1'b1, overflow, 1);
        chk("busy_off_queued", busy === 1'b1, busy, 1);
        idle(1);
        clr_ovf = 1'b1;
        @(negedge CLK);
        clr_ovf = 1'b0;
        chk("ovf_cleared", overflow === 1'b0, overflow, 0);
        wr_en = 1'b1; wr_data = 9'h1FF; clr_ovf = 1'b1;
        @(negedge CLK);
        wr_en = 1'b0; clr_ovf = 1'b0;
        chk("ovf_drop_wins", overflow === 1'b1, overflow, 1);
        clr_ovf = 1'b1;
        @(negedge CLK);
        clr_ovf = 1'b0;
        chk("ovf_cleared2", overflow === 1'b0, overflow, 0);

        // Power-up sequence timing, cycle 1 is the first after power_en is sampled
        vcc_on = 1'b1;
        power_en = 1'b1;
        first_res = 0; res_cnt = 0; first_ready = 0; pmod1 = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge CLK);
            if (k == 1) pmod1 = OLED_PMOD_EN;
            if (!OLED_RES) begin
                res_cnt++;
                if (first_res == 0) first_res = k;
            end
            if (ready && first_ready == 0) first_ready = k;
        end
        chk("pmod_next_cycle", pmod1 === 1'b1, pmod1, 1);
        chk("res_first_low", first_res === 5, first_res, 5);
        chk("res_low_cycles", res_cnt === 3, res_cnt, 3);
        chk("ready_cycle", first_ready === 11, first_ready, 11);
        chk("vcc_en_on", OLED_VCC_EN === 1'b1, OLED_VCC_EN, 1);

        // The four queued entries drain in order; dropped pushes never appear
        wait_rx(4, 300);
        for (int i = 0; i < 4; i++)
            chk("queued_byte", rx_q[i].data === qd[i], rx_q[i].data, qd[i]);
        chk("queued_bits", rx_q[0].nb === 8, rx_q[0].nb, 8);
        chk("queued_cs_len", rx_q[0].len === 18 * CLK_DIV, rx_q[0].len, 18 * CLK_DIV);
        chk("queued_spacing", (rx_q[1].start - rx_q[0].start) === 19 * CLK_DIV + 1,
            rx_q[1].start - rx_q[0].start, 19 * CLK_DIV + 1);
        idle(100);
        chk("dropped_not_sent", rx_q.size() === 4, rx_q.size(), 4);
        chk("busy_drained", busy === 1'b0, busy, 0);

        // Single byte latency, framing and bit order
        rx_q.delete();
        push_cyc = cyc + 1;
        push(9'h1A5);
        wait_rx(1, 100);
        idle(5);
        chk("single_latency", (rx_q[0].start - push_cyc) === 1, rx_q[0].start - push_cyc, 1);
        chk("single_data", rx_q[0].data === 9'h1A5, rx_q[0].data, 9'h1A5);
        chk("single_bits", rx_q[0].nb === 8, rx_q[0].nb, 8);
        chk("single_cs_len", rx_q[0].len === 36, rx_q[0].len, 36);
        chk("single_busy_fall", (busy_fall - rx_q[0].stop) === 2, busy_fall - rx_q[0].stop, 2);

        // Back-to-back commands
        rx_q.delete();
        wr_en = 1'b1; wr_data = 9'h0AE;
        @(negedge CLK);
        wr_data = 9'h0AF;
        @(negedge CLK);
        wr_en = 1'b0;
        wait_rx(2, 200);
        chk("b2b_first", rx_q[0].data === 9'h0AE, rx_q[0].data, 9'h0AE);
        chk("b2b_second", rx_q[1].data === 9'h0AF, rx_q[1].data, 9'h0AF);
        chk("b2b_cs_high", (rx_q[1].start - rx_q[0].stop) === 3, rx_q[1].start - rx_q[0].stop, 3);
        chk("b2b_spacing", (rx_q[1].start - rx_q[0].start) === 39, rx_q[1].start - rx_q[0].start, 39);

        // Power-down during SHIFT: byte completes, then OFF and FIFO flush
        rx_q.delete();
        wr_en = 1'b1; wr_data = 9'h0C3;
        @(negedge CLK);
        wr_data = 9'h13C;
        @(negedge CLK);
        wr_en = 1'b0;
        wait_sck(40);
        power_en = 1'b0;
        wait_rx(1, 100);
        chk("pd_byte", rx_q[0].data === 9'h0C3, rx_q[0].data, 9'h0C3);
        chk("pd_bits", rx_q[0].nb === 8, rx_q[0].nb, 8);
        chk("pd_pmod_in_gap", rx_q[0].pmod === 1'b1, rx_q[0].pmod, 1);
        idle(4);
        chk("pd_pmod", OLED_PMOD_EN === 1'b0, OLED_PMOD_EN, 0);
        chk("pd_vcc", OLED_VCC_EN === 1'b0, OLED_VCC_EN, 0);
        chk("pd_busy", busy === 1'b0, busy, 0);
        chk("pd_ready", ready === 1'b0, ready, 0);
        power_en = 1'b1;
        idle(12);
        chk("repower_ready", ready === 1'b1, ready, 1);
        idle(100);
        chk("pd_flushed", rx_q.size() === 1, rx_q.size(), 1);

        // Reset during SHIFT
        rx_q.delete();
        wr_en = 1'b1; wr_data = 9'h0F0;
        @(negedge CLK);
        wr_data = 9'h00F;
        @(negedge CLK);
        wr_en = 1'b0;
        wait_sck(40);
        reset = 1'b1;
        @(negedge CLK);
        chk("mr_cs", OLED_CS === 1'b1, OLED_CS, 1);
        chk("mr_sck", OLED_SCK === 1'b0, OLED_SCK, 0);
        chk("mr_mosi", OLED_MOSI === 1'b0, OLED_MOSI, 0);
        chk("mr_pmod", OLED_PMOD_EN === 1'b0, OLED_PMOD_EN, 0);
        chk("mr_ready", ready === 1'b0, ready, 0);
        chk("mr_busy", busy === 1'b0, busy, 0);
        reset = 1'b0;
        @(negedge CLK);
        rx_q.delete();
        idle(112);
        chk("mr_ready_again", ready === 1'b1, ready, 1);
        chk("mr_entries_lost", rx_q.size() === 0, rx_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time budget exceeded, observed running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
